// File: rtl/ultra_echo_meas.sv
`default_nettype none
// ============================================================================
// Module      : ultra_echo_meas
// Description : Ultrasonic trigger/echo timer producing a 16-bit distance in
//               cm with a held data-available pulse. Optional echo glitch
//               filter enabled by defining ULTRA_ECHO_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ultra_echo_meas #(
    parameter int TRIG_CYCLES      = 1000,
    parameter int CYCLES_PER_CM    = 5800,
    parameter int MAX_CM           = 400,
    parameter int ECHO_WAIT_CYCLES = 100000,
    parameter int PERIOD_CYCLES    = 6000000,
    parameter int AV_HOLD_CYCLES   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        echo_ai,
    output logic        trig_o,
    output logic [15:0] data_o,
    output logic        data_av_o,
    output logic        timeout_o,
    output logic        busy_o
);

    localparam int C_TRIG_W   = (TRIG_CYCLES      > 1) ? $clog2(TRIG_CYCLES)      : 1;
    localparam int C_WAIT_W   = (ECHO_WAIT_CYCLES > 1) ? $clog2(ECHO_WAIT_CYCLES) : 1;
    localparam int C_PRESC_W  = (CYCLES_PER_CM    > 1) ? $clog2(CYCLES_PER_CM)    : 1;
    localparam int C_PERIOD_W = (PERIOD_CYCLES    > 1) ? $clog2(PERIOD_CYCLES)    : 1;
    localparam int C_AV_W     = (AV_HOLD_CYCLES   > 1) ? $clog2(AV_HOLD_CYCLES)   : 1;

    localparam logic [C_TRIG_W-1:0]   C_TRIG_LAST   = C_TRIG_W'(TRIG_CYCLES - 1);
    localparam logic [C_WAIT_W-1:0]   C_WAIT_LAST   = C_WAIT_W'(ECHO_WAIT_CYCLES - 1);
    localparam logic [C_PRESC_W-1:0]  C_PRESC_LAST  = C_PRESC_W'(CYCLES_PER_CM - 1);
    localparam logic [C_PERIOD_W-1:0] C_PERIOD_LAST = C_PERIOD_W'(PERIOD_CYCLES - 1);
    localparam logic [C_AV_W-1:0]     C_AV_LAST     = C_AV_W'(AV_HOLD_CYCLES - 1);
    localparam logic [15:0]           C_MAX_CM      = 16'(MAX_CM);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_ECHO = 3'd2,
        S_MEASURE   = 3'd3,
        S_REPORT    = 3'd4,
        S_HOLDOFF   = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_echo_meta;
    logic                  r_echo_sync;
    logic                  w_echo_s;
    logic [C_TRIG_W-1:0]   r_trig_cnt;
    logic [C_WAIT_W-1:0]   r_wait_cnt;
    logic [C_PRESC_W-1:0]  r_presc;
    logic [C_PERIOD_W-1:0] r_period_cnt;
    logic [C_AV_W-1:0]     r_av_cnt;
    logic [15:0]           r_cm;
    logic                  w_wrap;
    logic [15:0]           w_cm_next;
    logic                  w_period_done;
    logic                  w_start_ok;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_echo_meta <= 1'b0;
            r_echo_sync <= 1'b0;
        end else begin
            r_echo_meta <= echo_ai;
            r_echo_sync <= r_echo_meta;
        end
    end

`ifdef ULTRA_ECHO_GLITCH_FILTER_EN
    // The filtered level only follows after three agreeing synchronised samples.
    logic [1:0] r_echo_hist;
    logic       r_echo_filt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_echo_hist <= 2'b00;
            r_echo_filt <= 1'b0;
        end else begin
            r_echo_hist <= {r_echo_hist[0], r_echo_sync};
            if (r_echo_hist == {2{r_echo_sync}}) begin
                r_echo_filt <= r_echo_sync;
            end
        end
    end

    assign w_echo_s = r_echo_filt;
`else
    assign w_echo_s = r_echo_sync;
`endif

    assign w_wrap        = (r_presc == C_PRESC_LAST);
    assign w_cm_next     = r_cm + 16'(w_wrap);
    assign w_period_done = (r_period_cnt == C_PERIOD_LAST);
    assign w_start_ok    = enable_i && !w_echo_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            trig_o       <= 1'b0;
            data_o       <= '0;
            data_av_o    <= 1'b0;
            timeout_o    <= 1'b0;
            busy_o       <= 1'b0;
            r_trig_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_presc      <= '0;
            r_period_cnt <= '0;
            r_av_cnt     <= '0;
            r_cm         <= '0;
        end else begin
            // Saturates so a long IDLE stretch cannot wrap it; cleared on TRIG entry.
            if (!w_period_done) begin
                r_period_cnt <= r_period_cnt + C_PERIOD_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_state      <= S_TRIG;
                        trig_o       <= 1'b1;
                        busy_o       <= 1'b1;
                        r_trig_cnt   <= '0;
                        r_period_cnt <= '0;
                    end
                end

                S_TRIG: begin
                    if (r_trig_cnt == C_TRIG_LAST) begin
                        r_state    <= S_WAIT_ECHO;
                        trig_o     <= 1'b0;
                        r_wait_cnt <= '0;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + C_TRIG_W'(1);
                    end
                end

                S_WAIT_ECHO: begin
                    if (w_echo_s) begin
                        r_state <= S_MEASURE;
                        r_presc <= '0;
                        r_cm    <= '0;
                    end else if (r_wait_cnt == C_WAIT_LAST) begin
                        r_state   <= S_REPORT;
                        data_o    <= C_MAX_CM;
                        timeout_o <= 1'b1;
                        data_av_o <= 1'b1;
                        r_av_cnt  <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + C_WAIT_W'(1);
                    end
                end

                S_MEASURE: begin
                    // A wrap coinciding with the echo fall still counts.
                    if (!w_echo_s) begin
                        r_state   <= S_REPORT;
                        data_o    <= w_cm_next;
                        timeout_o <= 1'b0;
                        data_av_o <= 1'b1;
                        r_av_cnt  <= '0;
                    end else if (w_cm_next == C_MAX_CM) begin
                        r_state   <= S_REPORT;
                        data_o    <= C_MAX_CM;
                        timeout_o <= 1'b1;
                        data_av_o <= 1'b1;
                        r_av_cnt  <= '0;
                    end else begin
                        r_presc <= w_wrap ? '0 : r_presc + C_PRESC_W'(1);
                        r_cm    <= w_cm_next;
                    end
                end

                S_REPORT: begin
                    if (r_av_cnt == C_AV_LAST) begin
                        r_state   <= S_HOLDOFF;
                        data_av_o <= 1'b0;
                    end else begin
                        r_av_cnt <= r_av_cnt + C_AV_W'(1);
                    end
                end

                S_HOLDOFF: begin
                    if (w_period_done) begin
                        if (w_start_ok) begin
                            r_state      <= S_TRIG;
                            trig_o       <= 1'b1;
                            r_trig_cnt   <= '0;
                            r_period_cnt <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    trig_o    <= 1'b0;
                    data_av_o <= 1'b0;
                    busy_o    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
